// File: rtl/mips_core_pkg.sv
// Shared core types: branch outcome encoding plus the BTB entry record and counter constants.
package mips_core_pkg;

  localparam int ADDR_WIDTH = 32;

  typedef enum logic {
    NOT_TAKEN = 1'b0,
    TAKEN     = 1'b1
  } BranchOutcome;

  // The tag field is sized for the smallest possible index (INDEX_BITS=0).
  // Narrower tags are zero-extended, so their upper bits are constant.
  localparam int BTB_TAG_MAX_W = ADDR_WIDTH - 2;

  localparam logic [1:0] BTB_CNT_INIT_TAKEN   = 2'b10;
  localparam logic [1:0] BTB_CNT_STRONG_TAKEN = 2'b11;

  typedef struct packed {
    logic                     valid;
    logic [BTB_TAG_MAX_W-1:0] tag;
    logic [ADDR_WIDTH-1:0]    target;
    logic [1:0]               cnt;
  } btb_entry_t;

endpackage

// File: rtl/btb_sat_counter.sv
// Two-bit saturating counter next-state function, stepped by a resolved branch outcome.
module btb_sat_counter
  import mips_core_pkg::*;
(
  input  logic [1:0]   i_cnt,
  input  BranchOutcome i_outcome,
  output logic [1:0]   o_cnt
);

  always_comb begin
    o_cnt = i_cnt;
    if (i_outcome == TAKEN) begin
      if (i_cnt != 2'b11) o_cnt = i_cnt + 2'd1;
    end else begin
      if (i_cnt != 2'b00) o_cnt = i_cnt - 2'd1;
    end
  end

endmodule

// File: rtl/branch_target_buffer.sv
// Direct-mapped fetch-stage BTB: zero-latency lookup from registered entries,
// trained by EX-stage branch/jump feedback, with lookup and hit performance counters.
module branch_target_buffer
  import mips_core_pkg::*;
#(
  parameter int INDEX_BITS = 6,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_lookup_valid,
  input  logic [ADDR_WIDTH-1:0] i_lookup_pc,
  output logic                  o_hit,
  output logic                  o_pred_taken,
  output logic [ADDR_WIDTH-1:0] o_pred_target,
  input  logic                  i_flush,
  input  logic                  i_upd_valid,
  input  logic [ADDR_WIDTH-1:0] i_upd_pc,
  input  logic [ADDR_WIDTH-1:0] i_upd_target,
  input  logic                  i_upd_is_jump,
  input  BranchOutcome          i_upd_outcome,
  output logic [CNT_WIDTH-1:0]  o_lookup_count,
  output logic [CNT_WIDTH-1:0]  o_hit_count
);

  localparam int ENTRIES = 1 << INDEX_BITS;

  btb_entry_t               r_entries [ENTRIES];
  logic [CNT_WIDTH-1:0]     r_lookup_count;
  logic [CNT_WIDTH-1:0]     r_hit_count;

  logic [INDEX_BITS-1:0]    w_lk_idx;
  logic [INDEX_BITS-1:0]    w_up_idx;
  logic [BTB_TAG_MAX_W-1:0] w_lk_tag;
  logic [BTB_TAG_MAX_W-1:0] w_up_tag;
  btb_entry_t               w_lk_entry;
  btb_entry_t               w_up_entry;
  btb_entry_t               w_up_new;
  logic                     w_up_hit;
  logic                     w_up_we;
  logic [1:0]               w_sat_cnt;
  logic                     w_unused;

  // pc[1:0] never participates in indexing or tagging.
  assign w_unused = ^{i_lookup_pc[1:0], i_upd_pc[1:0]};

  assign w_lk_idx   = i_lookup_pc[INDEX_BITS+1:2];
  assign w_lk_tag   = BTB_TAG_MAX_W'(i_lookup_pc[ADDR_WIDTH-1:INDEX_BITS+2]);
  assign w_lk_entry = r_entries[w_lk_idx];

  assign o_hit         = i_lookup_valid & w_lk_entry.valid & (w_lk_entry.tag == w_lk_tag);
  assign o_pred_taken  = o_hit & w_lk_entry.cnt[1];
  assign o_pred_target = o_pred_taken ? w_lk_entry.target : i_lookup_pc + ADDR_WIDTH'(4);

  assign w_up_idx   = i_upd_pc[INDEX_BITS+1:2];
  assign w_up_tag   = BTB_TAG_MAX_W'(i_upd_pc[ADDR_WIDTH-1:INDEX_BITS+2]);
  assign w_up_entry = r_entries[w_up_idx];
  assign w_up_hit   = w_up_entry.valid & (w_up_entry.tag == w_up_tag);

  btb_sat_counter u_sat (
    .i_cnt     (w_up_entry.cnt),
    .i_outcome (i_upd_outcome),
    .o_cnt     (w_sat_cnt)
  );

  // Flush takes priority, so an update arriving with it is simply dropped.
  always_comb begin
    w_up_we  = 1'b0;
    w_up_new = w_up_entry;
    if (i_upd_valid && !i_flush) begin
      if (w_up_hit) begin
        w_up_we = 1'b1;
        if (i_upd_is_jump) begin
          w_up_new.cnt    = BTB_CNT_STRONG_TAKEN;
          w_up_new.target = i_upd_target;
        end else begin
          w_up_new.cnt = w_sat_cnt;
          if (i_upd_outcome == TAKEN) w_up_new.target = i_upd_target;
        end
      end else if (i_upd_is_jump || (i_upd_outcome == TAKEN)) begin
        w_up_we         = 1'b1;
        w_up_new.valid  = 1'b1;
        w_up_new.tag    = w_up_tag;
        w_up_new.target = i_upd_target;
        w_up_new.cnt    = i_upd_is_jump ? BTB_CNT_STRONG_TAKEN : BTB_CNT_INIT_TAKEN;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) r_entries[i] <= '0;
      r_lookup_count <= '0;
      r_hit_count    <= '0;
    end else begin
      if (i_lookup_valid) r_lookup_count <= r_lookup_count + CNT_WIDTH'(1);
      if (o_hit)          r_hit_count    <= r_hit_count + CNT_WIDTH'(1);
      if (i_flush) begin
        for (int i = 0; i < ENTRIES; i++) r_entries[i].valid <= 1'b0;
      end else if (w_up_we) begin
        r_entries[w_up_idx] <= w_up_new;
      end
    end
  end

  assign o_lookup_count = r_lookup_count;
  assign o_hit_count    = r_hit_count;

endmodule

// File: tb/tb_branch_target_buffer.sv
// Bench for branch_target_buffer: directed vector table, randomized traffic against
// an array-based reference model, counter wrap and asynchronous reset sequences.
module tb_branch_target_buffer;
  import mips_core_pkg::*;

  localparam int IB = 6;
  localparam int CW = 4;
  localparam int NENT = 64;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  i_lookup_valid;
  logic [ADDR_WIDTH-1:0] i_lookup_pc;
  logic                  o_hit;
  logic                  o_pred_taken;
  logic [ADDR_WIDTH-1:0] o_pred_target;
  logic                  i_flush;
  logic                  i_upd_valid;
  logic [ADDR_WIDTH-1:0] i_upd_pc;
  logic [ADDR_WIDTH-1:0] i_upd_target;
  logic                  i_upd_is_jump;
  BranchOutcome          i_upd_outcome;
  logic [CW-1:0]         o_lookup_count;
  logic [CW-1:0]         o_hit_count;

  branch_target_buffer #(.INDEX_BITS(IB), .CNT_WIDTH(CW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_lookup_valid (i_lookup_valid),
    .i_lookup_pc    (i_lookup_pc),
    .o_hit          (o_hit),
    .o_pred_taken   (o_pred_taken),
    .o_pred_target  (o_pred_target),
    .i_flush        (i_flush),
    .i_upd_valid    (i_upd_valid),
    .i_upd_pc       (i_upd_pc),
    .i_upd_target   (i_upd_target),
    .i_upd_is_jump  (i_upd_is_jump),
    .i_upd_outcome  (i_upd_outcome),
    .o_lookup_count (o_lookup_count),
    .o_hit_count    (o_hit_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        lk_valid;
    logic [31:0] lk_pc;
    logic        flush;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic [31:0] upd_tgt;
    logic        jump;
    logic        taken;
    logic        e_hit;
    logic        e_taken;
    logic [31:0] e_tgt;
  } vec_t;

  int total = 0;
  int bad   = 0;

  // Reference model: one record per index, arithmetic split of the PC.
  bit          m_valid  [NENT];
  int unsigned m_tag    [NENT];
  logic [31:0] m_target [NENT];
  int          m_cnt    [NENT];
  int unsigned m_lk = 0;
  int unsigned m_ht = 0;

  function automatic int m_idx(input logic [31:0] pc);
    return int'((pc / 4) % NENT);
  endfunction

  function automatic int unsigned m_tagof(input logic [31:0] pc);
    return pc / (4 * NENT);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NENT; i++) m_valid[i] = 1'b0;
    m_lk = 0;
    m_ht = 0;
  endtask

  task automatic model_predict(input vec_t v, output bit hit, output bit tk, output logic [31:0] tgt);
    int i;
    i   = m_idx(v.lk_pc);
    hit = v.lk_valid && m_valid[i] && (m_tag[i] == m_tagof(v.lk_pc));
    tk  = hit && (m_cnt[i] >= 2);
    tgt = tk ? m_target[i] : v.lk_pc + 32'd4;
  endtask

  task automatic model_update(input vec_t v);
    int i;
    bit hit;
    i = m_idx(v.upd_pc);
    if (v.flush) begin
      for (int k = 0; k < NENT; k++) m_valid[k] = 1'b0;
    end else if (v.upd_valid) begin
      hit = m_valid[i] && (m_tag[i] == m_tagof(v.upd_pc));
      if (hit) begin
        if (v.jump) begin
          m_cnt[i] = 3;  m_target[i] = v.upd_tgt;
        end else if (v.taken) begin
          m_cnt[i] = (m_cnt[i] == 3) ? 3 : m_cnt[i] + 1;
          m_target[i] = v.upd_tgt;
        end else begin
          m_cnt[i] = (m_cnt[i] == 0) ? 0 : m_cnt[i] - 1;
        end
      end else if (v.jump || v.taken) begin
        m_valid[i] = 1'b1;  m_tag[i] = m_tagof(v.upd_pc);
        m_target[i] = v.upd_tgt;  m_cnt[i] = v.jump ? 3 : 2;
      end
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input bit lv, input logic [31:0] lpc, input bit fl, input bit uv,
                              input logic [31:0] upc, input logic [31:0] ut, input bit j,
                              input bit t, input bit eh, input bit et, input logic [31:0] etg);
    vec_t v;
    v.lk_valid = lv;  v.lk_pc = lpc;  v.flush = fl;  v.upd_valid = uv;
    v.upd_pc = upc;  v.upd_tgt = ut;  v.jump = j;  v.taken = t;
    v.e_hit = eh;  v.e_taken = et;  v.e_tgt = etg;
    return v;
  endfunction

  // One cycle: drive just after posedge, check lookup mid-cycle, check counters after the edge.
  task automatic step(input vec_t v, input bit use_tbl, input string nm);
    bit          e_hit, e_tk, mh;
    logic [31:0] e_tgt;
    i_lookup_valid = v.lk_valid;
    i_lookup_pc    = v.lk_pc;
    i_flush        = v.flush;
    i_upd_valid    = v.upd_valid;
    i_upd_pc       = v.upd_pc;
    i_upd_target   = v.upd_tgt;
    i_upd_is_jump  = v.jump;
    i_upd_outcome  = v.taken ? TAKEN : NOT_TAKEN;
    #1;
    model_predict(v, e_hit, e_tk, e_tgt);
    mh = e_hit;
    if (use_tbl) begin
      e_hit = v.e_hit;  e_tk = v.e_taken;  e_tgt = v.e_tgt;
    end
    chk({nm, "_hit"},    32'(o_hit),        32'(e_hit));
    chk({nm, "_taken"},  32'(o_pred_taken), 32'(e_tk));
    chk({nm, "_target"}, o_pred_target,     e_tgt);
    @(posedge clk);
    model_update(v);
    if (v.lk_valid) m_lk++;
    if (mh) m_ht++;
    #1;
    chk({nm, "_lookup_count"}, 32'(o_lookup_count), m_lk % 16);
    chk({nm, "_hit_count"},    32'(o_hit_count),    m_ht % 16);
  endtask

  function automatic logic [31:0] rand_pc();
    logic [31:0] p;
    p = 32'h00400000 | (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 7)) << 2)
        | 32'($urandom_range(0, 3));
    return p;
  endfunction

  localparam logic [31:0] P0 = 32'h00400010, P1 = 32'h00400110, P2 = 32'h00400200;
  localparam logic [31:0] T0 = 32'h00400100, T1 = 32'h00400800, T2 = 32'h00400300;

  vec_t tbl [17];
  vec_t v;

  initial begin
    tbl[0]  = mk(1, P0, 0, 0, 0,  0,  0, 0, 0, 0, 32'h00400014);
    tbl[1]  = mk(0, P0, 0, 1, P0, T0, 0, 1, 0, 0, 32'h00400014);
    tbl[2]  = mk(1, P0, 0, 1, P0, 0,  0, 0, 1, 1, T0);            // same-cycle: old state
    tbl[3]  = mk(1, P0, 0, 1, P0, 0,  0, 0, 1, 0, 32'h00400014);
    tbl[4]  = mk(1, P0, 0, 1, P0, 0,  0, 0, 1, 0, 32'h00400014);
    tbl[5]  = mk(1, P0, 0, 1, P0, T0, 0, 1, 1, 0, 32'h00400014);
    tbl[6]  = mk(1, P0, 0, 0, 0,  0,  0, 0, 1, 0, 32'h00400014);
    tbl[7]  = mk(1, P0, 0, 1, P0, T0, 0, 1, 1, 0, 32'h00400014);
    tbl[8]  = mk(1, P0, 0, 1, P1, T1, 1, 1, 1, 1, T0);
    tbl[9]  = mk(1, P0, 0, 0, 0,  0,  0, 0, 0, 0, 32'h00400014);
    tbl[10] = mk(1, P1, 0, 1, P0, 0,  0, 0, 1, 1, T1);
    tbl[11] = mk(1, P1, 1, 1, P2, T2, 0, 1, 1, 1, T1);
    tbl[12] = mk(1, P1, 0, 0, 0,  0,  0, 0, 0, 0, 32'h00400114);
    tbl[13] = mk(1, P2, 0, 0, 0,  0,  0, 0, 0, 0, 32'h00400204);
    tbl[14] = mk(1, P2, 0, 1, P2, T2, 0, 1, 0, 0, 32'h00400204);
    tbl[15] = mk(1, P2, 0, 0, 0,  0,  0, 0, 1, 1, T2);
    tbl[16] = mk(0, P2, 0, 0, 0,  0,  0, 0, 0, 0, 32'h00400204);

    rst_n = 1'b0;
    i_lookup_valid = 1'b1;  i_lookup_pc = P0;
    i_flush = 1'b0;  i_upd_valid = 1'b0;  i_upd_pc = '0;  i_upd_target = '0;
    i_upd_is_jump = 1'b0;  i_upd_outcome = NOT_TAKEN;
    model_reset();
    #2;
    chk("reset_hit",          32'(o_hit),          32'd0);
    chk("reset_taken",        32'(o_pred_taken),   32'd0);
    chk("reset_target",       o_pred_target,       32'h00400014);
    chk("reset_lookup_count", 32'(o_lookup_count), 32'd0);
    chk("reset_hit_count",    32'(o_hit_count),    32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int r = 0; r < 17; r++) step(tbl[r], 1'b1, $sformatf("tbl%0d", r));

    for (int n = 0; n < 400; n++) begin
      v = '0;
      v.lk_valid  = ($urandom_range(0, 3) != 0);
      v.lk_pc     = rand_pc();
      v.flush     = ($urandom_range(0, 39) == 0);
      v.upd_valid = ($urandom_range(0, 1) == 1);
      v.upd_pc    = rand_pc();
      v.upd_tgt   = 32'h00500000 + (32'($urandom_range(0, 1023)) << 2);
      v.jump      = ($urandom_range(0, 4) == 0);
      v.taken     = ($urandom_range(0, 1) == 1);
      step(v, 1'b0, "rnd");
    end

    // Counter wrap from a fresh reset: one install, then 17 hitting lookups.
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    step(mk(0, P0, 0, 1, P0, T0, 1, 1, 0, 0, 32'h00400014), 1'b1, "wrap_install");
    for (int k = 0; k < 17; k++) step(mk(1, P0, 0, 0, 0, 0, 0, 0, 1, 1, T0), 1'b1, "wrap");
    chk("wrap_lookup_count", 32'(o_lookup_count), 32'd1);
    chk("wrap_hit_count",    32'(o_hit_count),    32'd1);

    // Asynchronous reset mid-cycle while a hitting lookup is presented.
    #1;
    chk("pre_async_hit", 32'(o_hit), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_hit",          32'(o_hit),          32'd0);
    chk("async_taken",        32'(o_pred_taken),   32'd0);
    chk("async_target",       o_pred_target,       32'h00400014);
    chk("async_lookup_count", 32'(o_lookup_count), 32'd0);
    chk("async_hit_count",    32'(o_hit_count),    32'd0);
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    step(mk(1, P0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h00400014), 1'b1, "post_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
